// File: rtl/tone_pkg.sv
// Shared definitions for the tone sample writer: note codes, the
// half-period lookup, FSM state encoding and the default amplitude.
package tone_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C4   = 3'd1;
  localparam logic [2:0] NOTE_D4   = 3'd2;
  localparam logic [2:0] NOTE_E4   = 3'd3;
  localparam logic [2:0] NOTE_F4   = 3'd4;
  localparam logic [2:0] NOTE_G4   = 3'd5;
  localparam logic [2:0] NOTE_A4   = 3'd6;
  localparam logic [2:0] NOTE_B4   = 3'd7;

  // Phase counter width; the longest half period (C4, 92) fits in 7 bits.
  localparam int HALF_W = 7;

  localparam logic [23:0] TONE_AMPLITUDE = 24'h1E8480;

  typedef enum logic [1:0] {
    S_PREP  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } tone_state_e;

  // Half period in 48 kHz samples. Rest maps to 1 so the table has no
  // zero entry; the phase is held during rest anyway.
  function automatic logic [HALF_W-1:0] half_period(input logic [2:0] n);
    logic [HALF_W-1:0] h;
    case (n)
      NOTE_C4: h = 7'd92;
      NOTE_D4: h = 7'd82;
      NOTE_E4: h = 7'd73;
      NOTE_F4: h = 7'd69;
      NOTE_G4: h = 7'd61;
      NOTE_A4: h = 7'd55;
      NOTE_B4: h = 7'd49;
      default: h = 7'd1;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tone_sample_writer_if.sv
// Codec write port: ready/strobe handshake carrying a stereo sample pair.
interface tone_sample_writer_if #(
  parameter int SAMPLE_W = 24
);
  logic                write_ready;
  logic                write;
  logic [SAMPLE_W-1:0] writedata_left;
  logic [SAMPLE_W-1:0] writedata_right;

  modport master (
    input  write_ready,
    output write, writedata_left, writedata_right
  );

  modport slave (
    output write_ready,
    input  write, writedata_left, writedata_right
  );
endinterface

// File: rtl/tone_phase_gen.sv
// Square-wave phase tracker: current note, sample count within the
// half period and output polarity. A load restarts the wave at the
// positive half and wins over a same-cycle advance.
module tone_phase_gen
  import tone_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       advance,
  input  logic       load,
  input  logic [2:0] note,
  output logic       polarity,
  output logic       active
);

  logic [2:0]        cur_note;
  logic [HALF_W-1:0] phase_cnt;
  logic              pol;

  // Phase advance per written sample; held while resting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_note  <= NOTE_REST;
      phase_cnt <= '0;
      pol       <= 1'b0;
    end else if (load) begin
      cur_note  <= note;
      phase_cnt <= '0;
      pol       <= 1'b0;
    end else if (advance && cur_note != NOTE_REST) begin
      if (phase_cnt == half_period(cur_note) - 7'd1) begin
        phase_cnt <= '0;
        pol       <= ~pol;
      end else begin
        phase_cnt <= phase_cnt + 7'd1;
      end
    end
  end

  assign polarity = pol;
  assign active   = (cur_note != NOTE_REST);

endmodule

// File: rtl/tone_sample_writer.sv
// Tone sample writer: forms a square-wave sample per 48 kHz codec slot
// and writes it to both DAC channels via the write_ready/write handshake.
// Optional macro TONE_DECAY_EN adds a stepwise amplitude decay per note.
module tone_sample_writer
  import tone_pkg::*;
#(
  parameter int                  SAMPLE_W            = 24,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE           = SAMPLE_W'(TONE_AMPLITUDE),
  parameter int                  DECAY_SHIFT_SAMPLES = 4096
)(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2:0]            note,
  input  logic                  note_load,
  input  logic                  mute,
  tone_sample_writer_if.master  codec
);

  tone_state_e         state;
  logic                write_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                polarity;
  logic                active;
  logic                advance;
  logic [SAMPLE_W-1:0] magnitude;
  logic [SAMPLE_W-1:0] mag_sat;
  logic [SAMPLE_W-1:0] sample_next;

  // Phase moves once per completed write.
  assign advance = (state == S_WRITE);

  tone_phase_gen u_phase (
    .clk      (clk),
    .resetn   (resetn),
    .advance  (advance),
    .load     (note_load),
    .note     (note),
    .polarity (polarity),
    .active   (active)
  );

`ifdef TONE_DECAY_EN
  localparam logic [SAMPLE_W-1:0] AMP_FLOOR = AMPLITUDE >> 4;

  logic [11:0]         decay_cnt;
  logic [SAMPLE_W-1:0] amp_q;

  // Halve the amplitude every DECAY_SHIFT_SAMPLES writes, never below the floor.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      decay_cnt <= '0;
      amp_q     <= AMPLITUDE;
    end else if (note_load) begin
      decay_cnt <= '0;
      amp_q     <= AMPLITUDE;
    end else if (advance) begin
      if (decay_cnt == 12'(DECAY_SHIFT_SAMPLES - 1)) begin
        decay_cnt <= '0;
        amp_q     <= ((amp_q >> 1) < AMP_FLOOR) ? AMP_FLOOR : (amp_q >> 1);
      end else begin
        decay_cnt <= decay_cnt + 12'd1;
      end
    end
  end

  assign magnitude = amp_q;
`else
  assign magnitude = AMPLITUDE;
`endif

  // Magnitude never exceeds AMPLITUDE, so negation cannot overflow.
  always_comb begin
    mag_sat     = (magnitude > AMPLITUDE) ? AMPLITUDE : magnitude;
    sample_next = '0;
    if (!mute && active)
      sample_next = polarity ? (~mag_sat + 1'b1) : mag_sat;
  end

  // Prep/wait/write handshake; write and data are registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_PREP;
      write_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      case (state)
        S_PREP: begin
          sample_q <= sample_next;
          write_q  <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (codec.write_ready) begin
            write_q <= 1'b1;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          write_q <= 1'b0;
          state   <= S_PREP;
        end
        default: begin
          write_q <= 1'b0;
          state   <= S_PREP;
        end
      endcase
    end
  end

  assign codec.write           = write_q;
  assign codec.writedata_left  = sample_q;
  assign codec.writedata_right = sample_q;

endmodule

// File: tb/tb_tone_sample_writer.sv
// Directed bench for tone_sample_writer: reset, first-write latency,
// A4 waveform, stall, load during write, mute, note sweep, async reset
// during write, and (with TONE_DECAY_EN) the amplitude decay steps.
module tb_tone_sample_writer;

  localparam logic [23:0] POS = 24'h1E8480;
  localparam logic [23:0] NEG = 24'hE17B80;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] note;
  logic       note_load;
  logic       mute;

  int n_chk  = 0;
  int n_fail = 0;

  tone_sample_writer_if #(.SAMPLE_W(24)) cif ();

  tone_sample_writer dut (
    .clk       (clk),
    .resetn    (resetn),
    .note      (note),
    .note_load (note_load),
    .mute      (mute),
    .codec     (cif)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          run;
    logic [23:0] val;
  } seg_t;

  typedef struct {
    logic [2:0] note;
    int         half;
  } note_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the next write pulse, sampled 1 time unit after posedge.
  task automatic wait_write(output logic [23:0] d);
    bit got = 0;
    d = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (cif.write === 1'b1) begin
        got = 1;
        d   = cif.writedata_left;
      end
    end
    if (!got) check("write_timeout", 32'd0, 32'd1);
  endtask

  // Pulse note_load across the edge that ends the current S_WRITE cycle.
  task automatic load_now(input logic [2:0] n);
    @(negedge clk);
    note      = n;
    note_load = 1'b1;
    @(negedge clk);
    note_load = 1'b0;
  endtask

  task automatic expect_run(input string name, input int run, input logic [23:0] val);
    logic [23:0] d;
    for (int i = 0; i < run; i++) begin
      wait_write(d);
      check(name, {8'd0, d}, {8'd0, val});
    end
  endtask

  // Protocol monitor: no back-to-back writes, channels always equal.
  logic prev_write = 1'b0;
  always @(posedge clk) begin
    #1;
    if (resetn === 1'b1) begin
      if (prev_write && cif.write) check("write_back_to_back", 32'd1, 32'd0);
      if (cif.write) check("left_eq_right", {8'd0, cif.writedata_right}, {8'd0, cif.writedata_left});
    end
    prev_write = cif.write;
  end

  initial begin
    seg_t        a4_tab[3];
    note_vec_t   sweep[7];
    logic [23:0] d;
    logic [23:0] held;
    int          found;

    a4_tab[0] = '{55, POS};
    a4_tab[1] = '{55, NEG};
    a4_tab[2] = '{55, POS};

    sweep[0] = '{3'd1, 92};
    sweep[1] = '{3'd2, 82};
    sweep[2] = '{3'd3, 73};
    sweep[3] = '{3'd4, 69};
    sweep[4] = '{3'd5, 61};
    sweep[5] = '{3'd7, 49};
    sweep[6] = '{3'd0, 0};

    resetn          = 1'b0;
    note            = 3'd0;
    note_load       = 1'b0;
    mute            = 1'b0;
    cif.write_ready = 1'b1;

    // Reset state with write_ready high
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_write", {31'd0, cif.write}, 32'd0);
      check("reset_data", {8'd0, cif.writedata_left}, 32'd0);
    end

    // First write: third cycle after release (second edge), rest data
    @(negedge clk);
    resetn = 1'b1;
    found  = 0;
    for (int k = 1; k <= 6 && found == 0; k++) begin
      @(posedge clk); #1;
      if (cif.write === 1'b1) found = k;
    end
    check("first_write_edge", found, 32'd2);
    check("first_write_data", {8'd0, cif.writedata_left}, 32'd0);

    // A4 loaded during a write: 55 positive, 55 negative, 55 positive
    load_now(3'd6);
    foreach (a4_tab[s]) expect_run("a4_seg", a4_tab[s].run, a4_tab[s].val);

    // Stall in S_WAIT for 100 cycles; the pending A4 sample is negative
    @(negedge clk);
    cif.write_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 held = cif.writedata_left;
    check("stall_held_value", {8'd0, held}, {8'd0, NEG});
    repeat (100) begin
      @(posedge clk); #1;
      check("stall_no_write", {31'd0, cif.write}, 32'd0);
      check("stall_data_stable", {8'd0, cif.writedata_left}, {8'd0, held});
    end
    @(negedge clk);
    cif.write_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_to_write", {31'd0, cif.write}, 32'd1);
    check("stall_write_data", {8'd0, cif.writedata_left}, {8'd0, NEG});

    // E4 loaded during that A4 write: 73 positive then negative
    load_now(3'd3);
    expect_run("e4_pos", 73, POS);
    expect_run("e4_neg", 1, NEG);

    // Mute for 20 writes; phase keeps running (neg half resumes at 21)
    @(negedge clk);
    mute = 1'b1;
    expect_run("mute_zero", 20, 24'd0);
    @(negedge clk);
    mute = 1'b0;
    expect_run("unmute_neg", 52, NEG);
    expect_run("unmute_pos", 1, POS);

    // Async reset while write is high
    #2 resetn = 1'b0;
    #1;
    check("async_reset_write", {31'd0, cif.write}, 32'd0);
    check("async_reset_data", {8'd0, cif.writedata_left}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Note sweep: every half period, then rest
    foreach (sweep[v]) begin
      wait_write(d);
      load_now(sweep[v].note);
      if (sweep[v].half > 0) begin
        expect_run("sweep_pos", sweep[v].half, POS);
        expect_run("sweep_neg", 1, NEG);
      end else begin
        expect_run("sweep_rest", 5, 24'd0);
      end
    end

`ifdef TONE_DECAY_EN
    // Decay: full for 4096 writes, halving each 4096, floored at AMPLITUDE>>4
    wait_write(d);
    load_now(3'd1);
    for (int k = 1; k <= 20488; k++) begin
      logic [23:0] mag;
      logic [23:0] exp_mag;
      wait_write(d);
      mag = d[23] ? (~d + 24'd1) : d;
      if      (k <= 4096)  exp_mag = 24'h1E8480;
      else if (k <= 8192)  exp_mag = 24'h0F4240;
      else if (k <= 12288) exp_mag = 24'h07A120;
      else if (k <= 16384) exp_mag = 24'h03D090;
      else                 exp_mag = 24'h01E848;
      check("decay_mag", {8'd0, mag}, {8'd0, exp_mag});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
